// File: rtl/image_rom_streamer_if.sv
// Pixel-stream / ROM-port bundle for image_rom_streamer.
// master: the streamer itself; slave: the environment (ROM + downstream sink).
interface image_rom_streamer_if;
  logic        start;
  logic        busy;
  logic        done;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  logic [7:0]  pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        pix_sof;
  logic        pix_eol;
  logic        pix_eof;

  modport master (
    input  start, rom_data, pix_ready,
    output busy, done, rom_addr, pix_data, pix_valid, pix_sof, pix_eol, pix_eof
  );

  modport slave (
    output start, rom_data, pix_ready,
    input  busy, done, rom_addr, pix_data, pix_valid, pix_sof, pix_eol, pix_eof
  );
endinterface

// File: rtl/image_rom_streamer.sv
// image_rom_streamer: raster-order reader of a synchronous image ROM that
// presents the image as a valid/ready pixel stream with SOF/EOL/EOF markers.
// ROM latency is hidden by a read pipeline feeding a ROM_LAT+2 deep FIFO;
// credit-based issue keeps the FIFO from overflowing under backpressure.
// Optional feature: define STREAM_CONTINUOUS_EN for free-running frames
// (address wraps, no DONE state, busy stays high until rst).
module image_rom_streamer #(
  parameter int IMG_W   = 256,
  parameter int IMG_H   = 256,
  parameter int ROM_LAT = 1
) (
  input logic                  clk,
  input logic                  rst,
  image_rom_streamer_if.master bus
);
  localparam int XW    = $clog2(IMG_W);
  localparam int YW    = $clog2(IMG_H);
  localparam int PW    = XW + YW;        // {y,x} is the linear address
  localparam int DEPTH = ROM_LAT + 2;
  localparam int PTRW  = $clog2(DEPTH);
  localparam int CNTW  = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic [7:0]    data;
    logic [PW-1:0] pos;
  } fifo_ent_t;

  state_t                   r_state, w_next_state;
  logic [PW-1:0]            r_pos;
  logic [15:0]              r_rom_addr;
  logic [ROM_LAT:0]         r_vld_pipe;
  logic [ROM_LAT:0][PW-1:0] r_pos_pipe;
  fifo_ent_t                r_fifo [DEPTH];
  logic [PTRW-1:0]          r_wr_ptr, r_rd_ptr;
  logic [CNTW-1:0]          r_cnt;
  fifo_ent_t                w_head;
  logic                     w_valid, w_pop, w_push, w_hs_eof, w_credit, w_issue;
  logic [3:0]               w_inflight;
`ifdef STREAM_CONTINUOUS_EN
  logic                     r_eof_hs;
`else
  logic                     w_last;
  assign w_last = &r_pos;
`endif

  assign w_head   = r_fifo[r_rd_ptr];
  assign w_valid  = (r_cnt != '0);
  assign w_pop    = w_valid && bus.pix_ready;
  assign w_push   = r_vld_pipe[ROM_LAT];
  assign w_hs_eof = w_pop && (&w_head.pos);

  // Reads in flight: address on the bus plus every pipeline stage up to douta.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i <= ROM_LAT; i++) w_inflight = w_inflight + 4'(r_vld_pipe[i]);
  end

  // Issue only if every outstanding read still has a FIFO slot; the pixel
  // leaving this cycle frees one, which keeps full rate with ready held high.
  assign w_credit = (4'(r_cnt) + w_inflight) < (4'(DEPTH) + {3'b000, w_pop});
  assign w_issue  = w_credit && ((r_state == S_IDLE && bus.start) || r_state == S_RUN);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next_state = S_RUN;
`ifdef STREAM_CONTINUOUS_EN
      S_RUN:   w_next_state = S_RUN;
`else
      S_RUN:   if (w_issue && w_last) w_next_state = S_DRAIN;
`endif
      S_DRAIN: if (w_hs_eof) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Raster position and ROM address; the power-of-two frame wraps to 0 by itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pos      <= '0;
      r_rom_addr <= '0;
    end else if (w_issue) begin
      r_rom_addr <= 16'(r_pos);
      r_pos      <= r_pos + 1'b1;
    end
  end

  // Read pipeline: stage ROM_LAT lines up with the matching douta.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_pipe <= '0;
      r_pos_pipe <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[ROM_LAT-1:0], w_issue};
      r_pos_pipe <= {r_pos_pipe[ROM_LAT-1:0], r_pos};
    end
  end

  // FIFO storage; contents are don't-care until counted valid.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= '{data: bus.rom_data, pos: r_pos_pipe[ROM_LAT]};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == PTRW'(DEPTH-1)) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == PTRW'(DEPTH-1)) ? '0 : r_rd_ptr + 1'b1;
      r_cnt <= r_cnt + CNTW'(w_push) - CNTW'(w_pop);
    end
  end

`ifdef STREAM_CONTINUOUS_EN
  // Frame-complete pulse one cycle after each EOF handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_eof_hs <= 1'b0;
    else     r_eof_hs <= w_hs_eof;
  end
`endif

  // Outputs: status from state, stream fields from the FIFO head (zero when empty).
  always_comb begin
    bus.busy      = (r_state != S_IDLE);
`ifdef STREAM_CONTINUOUS_EN
    bus.done      = r_eof_hs;
`else
    bus.done      = (r_state == S_DONE);
`endif
    bus.pix_valid = w_valid;
    bus.pix_data  = w_valid ? w_head.data : '0;
    bus.pix_sof   = w_valid && (w_head.pos == '0);
    bus.pix_eol   = w_valid && (&w_head.pos[XW-1:0]);
    bus.pix_eof   = w_valid && (&w_head.pos);
  end

  assign bus.rom_addr = r_rom_addr;
endmodule
